// File: rtl/key_debounce_arb.sv
// key_debounce_arb: one debounce timer shared round-robin among N_KEYS active-low buttons.
// A confirmed press emits a one-cycle key_pulse bit and a single-entry key-ID event.
module key_debounce_arb #(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = 240000,
  parameter int CNT_W      = 18,
  parameter int ID_W       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_pulse,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  input  logic              evt_ready,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id
);
  typedef enum logic [1:0] {IDLE, TIMING, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_KEYS - 1);

  state_t            state_q, state_d;
  logic [N_KEYS-1:0] s1_p0, s2_p1, prev_p2, fall;
  logic [N_KEYS-1:0] pend_q, pend_d, pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   grant_q, grant_d, last_q, last_d, evt_id_d, rr_idx, cand;
  logic              rr_hit, slot_free, evt_valid_d;

  // Stage p0/p1: two-flop synchroniser; stage p2: previous level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p0   <= '1;
      s2_p1   <= '1;
      prev_p2 <= '1;
    end else begin
      s1_p0   <= key;
      s2_p1   <= s1_p0;
      prev_p2 <= s2_p1;
    end
  end

  assign fall      = prev_p2 & ~s2_p1;
  assign slot_free = ~evt_valid | evt_ready;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

  // Round-robin search starting one past the last granted key
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      cand = ID_W'((int'(last_q) + k) % N_KEYS);
      if (!rr_hit && pend_q[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    pend_d      = pend_q;
    pulse_d     = '0;
    evt_valid_d = evt_valid & ~evt_ready;
    evt_id_d    = evt_id;
    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          grant_d = rr_idx;
          last_d  = rr_idx;
          cnt_d   = '0;
          state_d = TIMING;
        end
      end
      TIMING: begin
        if (fall[grant_q]) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = CHECK;
        end
      end
      CHECK: begin
        // Timer stays frozen while the event slot is occupied
        if (slot_free) begin
          if (!s2_p1[grant_q]) begin
            pulse_d[grant_q] = 1'b1;
            evt_valid_d      = 1'b1;
            evt_id_d         = grant_q;
          end
          pend_d[grant_q] = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = pend_d | fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      last_q    <= ID_LAST;
      pend_q    <= '0;
      key_pulse <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      key_pulse <= pulse_d;
      evt_valid <= evt_valid_d;
      evt_id    <= evt_id_d;
    end
  end

endmodule
